axi_cache_mem_master: RTL and testbench

AXI_CACHE_MEM_MASTER -- requirements
Module: axi_cache_mem_master

---
 rtl/axi_cache_pkg.sv | 32 +++
 rtl/axi_cache_mem_master.sv | 227 ++++++++++++++++++++++
 tb/tb_axi_cache_mem_master.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_cache_pkg.sv
// -----------------------------------------------------------------------------
// axi_cache_pkg
// Shared constants for the cache-side AXI memory master:
//   - FSM state encoding (legacy-compatible localparam constants)
//   - AXI response codes and the burst type assumed by the system
//   - helper to classify an AXI response as an error
// -----------------------------------------------------------------------------
package axi_cache_pkg;

    // FSM state encoding
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RD_ADDR = 3'd1;
    localparam logic [2:0] ST_RD_DATA = 3'd2;
    localparam logic [2:0] ST_WR_ADDR = 3'd3;
    localparam logic [2:0] ST_WR_DATA = 3'd4;
    localparam logic [2:0] ST_WR_RESP = 3'd5;

    // AXI response codes
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // The interconnect ties AxBURST to INCR; there is no burst port on the master.
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

    // SLVERR and DECERR both have bit 1 set; OKAY/EXOKAY do not.
    function automatic logic axi_resp_is_err(input logic [1:0] resp);
        return resp[1];
    endfunction

endpackage

// File: rtl/axi_cache_mem_master.sv
// -----------------------------------------------------------------------------
// axi_cache_mem_master
// Converts single line-fill / line-writeback requests from a cache into AXI4
// INCR bursts. Exactly one transaction is outstanding at a time.
//
// Optional feature (compile-time macro AXI_MEM_MASTER_ERR_EN):
//   defined   : mem_err reports RRESP[1] / BRESP[1] / early-rlast seen during
//               the transaction, cleared when the next request is accepted.
//   undefined : mem_err is constant 0 and response codes are ignored.
//
// Ports
//   m_axi_aclk, m_axi_areset    clock, synchronous active-high reset
//   mem_req/mem_rdy             cache request handshake (mem_rdy only in IDLE)
//   mem_wen, mem_addr, mem_len  request kind, byte address, beats-1
//   mem_wdata/mem_wstrb         writeback beat, held by cache until mem_wnext
//   mem_wnext                   writeback beat consumed this cycle
//   mem_rdata/mem_rvalid        fill beat, one-cycle pulse
//   mem_done/mem_err            completion pulse and its error qualifier
//   m_axi_aw*/w*/b*/ar*/r*      AXI4 master channels (no size/burst ports)
// -----------------------------------------------------------------------------
module axi_cache_mem_master
    import axi_cache_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32   // 32 or 64
) (
    input  logic                    m_axi_aclk,
    input  logic                    m_axi_areset,

    // cache side
    input  logic                    mem_req,
    output logic                    mem_rdy,
    input  logic                    mem_wen,
    input  logic [ADDR_WIDTH-1:0]   mem_addr,
    input  logic [7:0]              mem_len,
    input  logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH/8-1:0] mem_wstrb,
    output logic                    mem_wnext,
    output logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    mem_rvalid,
    output logic                    mem_done,
    output logic                    mem_err,

    // AW channel
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]              m_axi_awlen,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,

    // W channel
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wlast,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,

    // B channel
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,

    // AR channel
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [7:0]              m_axi_arlen,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,

    // R channel
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rlast,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready
);

    localparam int STRB_W = DATA_WIDTH / 8;
    // Clears the byte-offset bits so every burst starts on a beat boundary.
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(STRB_W - 1));

    logic [2:0]            state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_q;
    logic [7:0]            cnt_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  rvalid_q;
    logic                  done_q;
    logic                  err_q;

    logic                  accept;
    logic                  last_wbeat;
    logic                  rd_beat_err;
    logic                  wr_resp_err;

    // -------------------------------------------------------------------------
    // Error classification
    // -------------------------------------------------------------------------
`ifdef AXI_MEM_MASTER_ERR_EN
    assign rd_beat_err = axi_resp_is_err(m_axi_rresp)
                       | (m_axi_rlast & (cnt_q != len_q));
    assign wr_resp_err = axi_resp_is_err(m_axi_bresp);
`else
    // Response codes are deliberately not observed in this build.
    logic unused_resp;
    assign unused_resp = ^{m_axi_rresp, m_axi_bresp};
    assign rd_beat_err = 1'b0;
    assign wr_resp_err = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Handshake / channel decode. VALID/READY are pure state decodes, so they
    // are held for the whole state and drop to 0 the cycle reset is applied.
    // -------------------------------------------------------------------------
    // Gating with reset keeps mem_rdy low while reset is held even though the
    // state register already reads IDLE.
    assign mem_rdy       = (state_q == ST_IDLE) && !m_axi_areset;
    assign accept        = mem_req && mem_rdy;

    assign m_axi_arvalid = (state_q == ST_RD_ADDR);
    assign m_axi_rready  = (state_q == ST_RD_DATA);
    assign m_axi_awvalid = (state_q == ST_WR_ADDR);
    assign m_axi_wvalid  = (state_q == ST_WR_DATA);
    assign m_axi_bready  = (state_q == ST_WR_RESP);

    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = len_q;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = len_q;

    // Writeback data streams straight from the cache; the cache holds the beat
    // until mem_wnext, which is exactly the W handshake.
    assign last_wbeat    = (cnt_q == len_q);
    assign m_axi_wdata   = mem_wdata;
    assign m_axi_wstrb   = mem_wstrb;
    assign m_axi_wlast   = m_axi_wvalid && last_wbeat;
    assign mem_wnext     = m_axi_wvalid && m_axi_wready;

    assign mem_rdata     = rdata_q;
    assign mem_rvalid    = rvalid_q;
    assign mem_done      = done_q;
    assign mem_err       = err_q;

    // -------------------------------------------------------------------------
    // Transaction FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge m_axi_aclk) begin
        if (m_axi_areset) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            // Single-cycle pulses default low.
            rvalid_q <= 1'b0;
            done_q   <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        addr_q  <= mem_addr & ALIGN_MASK;
                        len_q   <= mem_len;
                        cnt_q   <= '0;
                        err_q   <= 1'b0;
                        state_q <= mem_wen ? ST_WR_ADDR : ST_RD_ADDR;
                    end
                end

                ST_RD_ADDR: begin
                    if (m_axi_arready) begin
                        state_q <= ST_RD_DATA;
                    end
                end

                ST_RD_DATA: begin
                    if (m_axi_rvalid) begin
                        rdata_q  <= m_axi_rdata;
                        rvalid_q <= 1'b1;
                        // Saturate rather than wrap on a 256-beat burst.
                        if (cnt_q != 8'hFF) begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                        err_q <= err_q | rd_beat_err;
                        // The slave's rlast ends the burst even if it is early
                        // or late; a mismatch only raises mem_err.
                        if (m_axi_rlast) begin
                            done_q  <= 1'b1;
                            state_q <= ST_IDLE;
                        end
                    end
                end

                ST_WR_ADDR: begin
                    if (m_axi_awready) begin
                        state_q <= ST_WR_DATA;
                    end
                end

                ST_WR_DATA: begin
                    if (m_axi_wready) begin
                        if (cnt_q != 8'hFF) begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                        if (last_wbeat) begin
                            state_q <= ST_WR_RESP;
                        end
                    end
                end

                ST_WR_RESP: begin
                    if (m_axi_bvalid) begin
                        err_q   <= err_q | wr_resp_err;
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_cache_mem_master.sv
// -----------------------------------------------------------------------------
// tb_axi_cache_mem_master
// Directed bench for axi_cache_mem_master (ADDR_WIDTH=16, DATA_WIDTH=32).
// Expected fill data and writeback beats are queued as stimulus is driven and
// compared when the DUT produces mem_rdata / W beats.
// Error expectations follow AXI_MEM_MASTER_ERR_EN if it is defined.
// -----------------------------------------------------------------------------
module tb_axi_cache_mem_master;
    import axi_cache_pkg::*;

`ifdef AXI_MEM_MASTER_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req, mem_rdy, mem_wen, mem_wnext, mem_rvalid, mem_done, mem_err;
    logic [15:0] mem_addr;
    logic [7:0]  mem_len;
    logic [31:0] mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic [15:0] awaddr, araddr;
    logic [7:0]  awlen, arlen;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] rd_q[$];   // expected fill beats
    logic [36:0] wr_q[$];   // expected W beats {last, strb, data}

    always #5 clk = ~clk;

    axi_cache_mem_master #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) dut (
        .m_axi_aclk   (clk),
        .m_axi_areset (rst),
        .mem_req      (mem_req),
        .mem_rdy      (mem_rdy),
        .mem_wen      (mem_wen),
        .mem_addr     (mem_addr),
        .mem_len      (mem_len),
        .mem_wdata    (mem_wdata),
        .mem_wstrb    (mem_wstrb),
        .mem_wnext    (mem_wnext),
        .mem_rdata    (mem_rdata),
        .mem_rvalid   (mem_rvalid),
        .mem_done     (mem_done),
        .mem_err      (mem_err),
        .m_axi_awaddr (awaddr),
        .m_axi_awlen  (awlen),
        .m_axi_awvalid(awvalid),
        .m_axi_awready(awready),
        .m_axi_wdata  (wdata),
        .m_axi_wstrb  (wstrb),
        .m_axi_wlast  (wlast),
        .m_axi_wvalid (wvalid),
        .m_axi_wready (wready),
        .m_axi_bresp  (bresp),
        .m_axi_bvalid (bvalid),
        .m_axi_bready (bready),
        .m_axi_araddr (araddr),
        .m_axi_arlen  (arlen),
        .m_axi_arvalid(arvalid),
        .m_axi_arready(arready),
        .m_axi_rdata  (rdata),
        .m_axi_rresp  (rresp),
        .m_axi_rlast  (rlast),
        .m_axi_rvalid (rvalid),
        .m_axi_rready (rready)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic slave_idle();
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = AXI_RESP_OKAY;
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = AXI_RESP_OKAY; rdata = '0;
    endtask

    // Line fill. The slave returns base+beat, asserts rlast on beat last_at and
    // SLVERR on beat err_beat (-1 for none). Returns in the mem_done cycle.
    task automatic do_read(input logic [15:0] addr, input logic [7:0] len,
                           input int last_at, input int err_beat, input logic [31:0] base,
                           input bit exp_err, input bit hold, input string tag);
        int  cyc = 0, beat = 0, got = 0, dones = 0;
        bit  ar_done = 0, r_last_done = 0, ar_hs, r_hs;
        slave_idle();
        mem_req = 1'b1; mem_wen = 1'b0; mem_addr = addr; mem_len = len;
        #1;
        check({tag, "_rdy_at_req"}, mem_rdy, 1'b1);
        step();
        mem_req = hold;
        rd_q.delete();
        while (cyc < 400) begin
            arready = (cyc >= 1);
            rvalid = 1'b0; rlast = 1'b0; rresp = AXI_RESP_OKAY; rdata = '0;
            if (ar_done && !r_last_done && (cyc % 3 != 0)) begin
                rvalid = 1'b1;
                rdata  = base + 32'(beat);
                rlast  = (beat == last_at);
                rresp  = (beat == err_beat) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            end
            #1;
            if (cyc == 0) check({tag, "_arvalid_start"}, arvalid, 1'b1);
            if (arvalid) begin
                check({tag, "_araddr"}, araddr, addr & 16'hFFFC);
                check({tag, "_arlen"}, arlen, len);
            end
            if (mem_rvalid) begin
                check({tag, "_rd_q_nonempty"}, (rd_q.size() != 0), 1'b1);
                if (rd_q.size() != 0) check({tag, "_mem_rdata"}, mem_rdata, rd_q.pop_front());
                got++;
            end
            if (mem_done) begin
                dones++;
                check({tag, "_done_with_rvalid"}, mem_rvalid, 1'b1);
                check({tag, "_beats"}, got, last_at + 1);
                check({tag, "_rd_q_empty"}, rd_q.size(), 0);
                check({tag, "_mem_err"}, mem_err, exp_err);
                check({tag, "_rdy_at_done"}, mem_rdy, 1'b1);
                break;
            end
            check({tag, "_rdy_busy"}, mem_rdy, 1'b0);
            if (ar_done && !r_last_done) check({tag, "_rready"}, rready, 1'b1);
            ar_hs = arvalid && arready;
            r_hs  = rvalid && rready;
            if (r_hs) begin
                rd_q.push_back(rdata);
                if (rlast) r_last_done = 1;
                beat++;
            end
            step();
            cyc++;
            if (ar_hs) ar_done = 1;
        end
        check({tag, "_done_seen"}, dones, 1);
    endtask

    // Line writeback. toggle=1 makes wready alternate every cycle.
    task automatic do_write(input logic [15:0] addr, input logic [7:0] len, input bit toggle,
                            input logic [1:0] bresp_v, input bit exp_err, input bit hold,
                            input string tag);
        int  cyc = 0, widx = 0, nnext = 0, dones = 0;
        bit  aw_done = 0, w_done = 0, b_done = 0, aw_hs, w_hs, b_hs;
        logic [36:0] e;
        slave_idle();
        wr_q.delete();
        for (int i = 0; i <= int'(len); i++)
            wr_q.push_back({(i == int'(len)), 4'(i * 5 + 3), 32'hA500_0000 + 32'(addr) + 32'(i)});
        mem_req = 1'b1; mem_wen = 1'b1; mem_addr = addr; mem_len = len;
        mem_wdata = 32'hA500_0000 + 32'(addr); mem_wstrb = 4'd3;
        #1;
        check({tag, "_rdy_at_req"}, mem_rdy, 1'b1);
        step();
        mem_req = hold;
        while (cyc < 400) begin
            awready   = (cyc >= 1);
            wready    = toggle ? (cyc % 2 == 1) : 1'b1;
            bvalid    = w_done && !b_done;
            bresp     = bresp_v;
            mem_wdata = 32'hA500_0000 + 32'(addr) + 32'(widx);
            mem_wstrb = 4'(widx * 5 + 3);
            #1;
            if (cyc == 0) check({tag, "_awvalid_start"}, awvalid, 1'b1);
            if (awvalid) begin
                check({tag, "_awaddr"}, awaddr, addr & 16'hFFFC);
                check({tag, "_awlen"}, awlen, len);
            end
            check({tag, "_w_after_aw"}, (wvalid && !aw_done), 1'b0);
            check({tag, "_done_after_b"}, mem_done, b_done);
            if (mem_done) begin
                dones++;
                check({tag, "_mem_err"}, mem_err, exp_err);
                check({tag, "_rdy_at_done"}, mem_rdy, 1'b1);
                break;
            end
            check({tag, "_rdy_busy"}, mem_rdy, 1'b0);
            check({tag, "_wnext"}, mem_wnext, wvalid && wready);
            if (wvalid) begin
                check({tag, "_wlast_level"}, wlast, (widx == int'(len)));
            end
            w_hs = wvalid && wready;
            if (w_hs) begin
                check({tag, "_wr_q_nonempty"}, (wr_q.size() != 0), 1'b1);
                if (wr_q.size() != 0) begin
                    e = wr_q.pop_front();
                    check({tag, "_wdata"}, wdata, e[31:0]);
                    check({tag, "_wstrb"}, wstrb, e[35:32]);
                    check({tag, "_wlast"}, wlast, e[36]);
                end
            end
            aw_hs = awvalid && awready;
            b_hs  = bvalid && bready;
            step();
            cyc++;
            if (aw_hs) aw_done = 1;
            if (w_hs) begin
                nnext++;
                if (widx == int'(len)) w_done = 1;
                widx++;
            end
            if (b_hs) b_done = 1;
        end
        check({tag, "_done_seen"}, dones, 1);
        check({tag, "_wnext_count"}, nnext, int'(len) + 1);
        check({tag, "_wr_q_empty"}, wr_q.size(), 0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        mem_req = 1'b0; mem_wen = 1'b0; mem_addr = '0; mem_len = '0;
        mem_wdata = '0; mem_wstrb = '0;
        slave_idle();

        // Reset state
        step(); step(); step();
        check("rst_mem_rdy", mem_rdy, 1'b0);
        check("rst_valids", {awvalid, wvalid, bready, arvalid, rready}, 5'b0);
        check("rst_pulses", {mem_wnext, mem_rvalid, mem_done, mem_err}, 4'b0);
        check("rst_addr_len", {araddr, arlen, awaddr, awlen}, 48'h0);
        check("rst_rdata", mem_rdata, 32'h0);
        rst = 1'b0;
        #1;
        check("rst_release_rdy", mem_rdy, 1'b1);
        step();

        // 16-beat fill returning 0..15
        do_read(16'h1234, 8'd15, 15, -1, 32'd0, 1'b0, 1'b0, "fill16");
        step();

        // 4-beat writeback, unaligned address, wready toggling
        do_write(16'h0803, 8'd3, 1'b1, AXI_RESP_OKAY, 1'b0, 1'b0, "wb4");
        step();

        // SLVERR on second beat of a 2-beat fill
        do_read(16'h2000, 8'd1, 1, 1, 32'h5000_0000, ERR_EN, 1'b0, "fill_slverr");
        step();

        // Clean single-beat fill clears the error flag
        do_read(16'h3006, 8'd0, 0, -1, 32'hC0DE_0000, 1'b0, 1'b0, "fill_len0");
        step();

        // Early rlast on a 4-beat fill
        do_read(16'h4000, 8'd3, 1, -1, 32'h7700_0000, ERR_EN, 1'b0, "fill_early_last");
        step();

        // Single-beat writeback with SLVERR response
        do_write(16'h0100, 8'd0, 1'b0, AXI_RESP_SLVERR, ERR_EN, 1'b0, "wb_len0_slverr");
        step();

        // mem_req held: write then read accepted right after mem_done
        do_write(16'h0400, 8'd1, 1'b0, AXI_RESP_OKAY, 1'b0, 1'b1, "b2b_wr");
        do_read(16'h0500, 8'd2, 2, -1, 32'h1111_0000, 1'b0, 1'b0, "b2b_rd");
        step();

        // Reset in the middle of an 8-beat writeback
        slave_idle();
        mem_req = 1'b1; mem_wen = 1'b1; mem_addr = 16'h0600; mem_len = 8'd7;
        #1;
        step();
        mem_req = 1'b0; awready = 1'b1; wready = 1'b1;
        n = 0;
        for (int c = 0; c < 50 && n < 2; c++) begin
            #1;
            if (mem_wnext) n++;
            step();
        end
        check("rst_mid_beats", n, 2);
        rst = 1'b1;
        step();
        check("rst_mid_valids", {awvalid, wvalid, bready, arvalid, rready}, 5'b0);
        check("rst_mid_pulses", {mem_wnext, mem_rvalid, mem_done, mem_err, mem_rdy}, 5'b0);
        check("rst_mid_addr", {awaddr, awlen}, 24'h0);
        rst = 1'b0;
        slave_idle();
        #1;
        check("rst_mid_release_rdy", mem_rdy, 1'b1);
        step();
        check("rst_mid_idle_rdy", mem_rdy, 1'b1);
        check("rst_mid_idle_wvalid", wvalid, 1'b0);

        // Normal operation after the abandoned burst
        do_read(16'h0700, 8'd3, 3, -1, 32'h2222_0000, 1'b0, 1'b0, "post_rst_fill");
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
